// File: rtl/lib_pkg.sv
// lib_pkg: library-wide tag type shared along the sub2 pipeline
package lib_pkg;
    typedef logic [3:0] our_t;
endpackage

// File: rtl/my_pkg.sv
// my_pkg: element, beat and bundle types for the sub2 -> sub_ser path
package my_pkg;
    typedef logic [7:0] my_t;
    localparam int SER_BEATS = 7;
    typedef logic [2:0] beat_t;
    typedef my_t [0:SER_BEATS-1] seq_t;
    typedef struct packed {
        my_t i;
        lib_pkg::our_t j;
        my_t [0:2] k;
        my_t [0:2] l;
    } bundle_t;
    typedef struct packed {
        bundle_t b;
`ifdef SUB_SER_PARITY_EN
        logic [SER_BEATS-1:0] par;
`endif
    } entry_t;
    // Beat order: i, k[0..2], l[0..2]
    function automatic seq_t beats(bundle_t b);
        return {b.i, b.k, b.l};
    endfunction
    function automatic logic [SER_BEATS-1:0] parity(bundle_t b);
        seq_t s;
        s = beats(b);
        for (int n = 0; n < SER_BEATS; n++) parity[n] = ^s[n];
    endfunction
endpackage

// File: rtl/sub_ser_fifo.sv
// sub_ser_fifo: DEPTH-entry synchronous FIFO; also exposes the entry behind the head
module sub_ser_fifo #(
    parameter int DEPTH = 2,
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     wdata,
    output T     head,
    output T     second,
    output logic full,
    output logic empty,
    output logic many
);
    localparam int AW = $clog2(DEPTH);
    T mem [DEPTH];
    logic [AW:0] wr, rd, cnt;
    logic [AW-1:0] rd1;
    assign cnt = wr - rd;
    assign rd1 = rd[AW-1:0] + AW'(1);
    assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign empty = wr == rd;
    assign many = cnt > (AW+1)'(1);
    assign head = mem[rd[AW-1:0]];
    assign second = mem[rd1];
    always_ff @(posedge clk) begin
        if (push) mem[wr[AW-1:0]] <= wdata;
        if (rst) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (push) wr <= wr + (AW+1)'(1);
            if (pop) rd <= rd + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/sub_ser.sv
// sub_ser: buffers sub2 bundles and serialises each into a 7-beat my_t stream.
// Optional SUB_SER_PARITY_EN adds out_par and par_err_cnt with per-element stored parity.
module sub_ser
    import my_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  my_t           in_i,
    input  lib_pkg::our_t in_j,
    input  my_t [0:2]     in_k,
    input  my_t           in_l [3],
    output logic          out_valid,
    input  logic          out_ready,
    output my_t           out_data,
    output lib_pkg::our_t out_tag,
    output logic          out_last
`ifdef SUB_SER_PARITY_EN
    ,
    output logic          out_par,
    output logic [7:0]    par_err_cnt
`endif
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_n;
    beat_t beat, beat_n;
    entry_t in_e, head, second, cur, cur_n;
    seq_t seq;
    logic full, empty, many, push, pop, acc;
    always_comb begin
        in_e = '0;
        in_e.b = '{i: in_i, j: in_j, k: in_k, l: {in_l[0], in_l[1], in_l[2]}};
`ifdef SUB_SER_PARITY_EN
        in_e.par = parity(in_e.b);
`endif
    end
    sub_ser_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .wdata(in_e),
        .head(head), .second(second), .full(full), .empty(empty), .many(many)
    );
    assign in_ready = !full;
    assign push = in_valid && in_ready;
    assign out_valid = state == SEND;
    assign acc = out_valid && out_ready;
    assign out_last = out_valid && beat == beat_t'(SER_BEATS-1);
    assign pop = acc && out_last;
    assign seq = beats(cur.b);
    assign out_data = seq[beat];
    assign out_tag = cur.b.j;
    // The burst head stays in the FIFO until its last beat; a same-edge push bypasses into cur
    always_comb begin
        state_n = state;
        beat_n = beat;
        cur_n = cur;
        if (state == IDLE && !empty) begin
            state_n = SEND;
            beat_n = '0;
            cur_n = head;
        end else if (pop) begin
            state_n = (many || push) ? SEND : IDLE;
            beat_n = '0;
            cur_n = many ? second : push ? in_e : cur;
        end else if (acc) begin
            beat_n = beat + beat_t'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat <= '0;
            cur <= '0;
        end else begin
            state <= state_n;
            beat <= beat_n;
            cur <= cur_n;
        end
    end
`ifdef SUB_SER_PARITY_EN
    assign out_par = ^out_data;
    always_ff @(posedge clk) begin
        if (rst) par_err_cnt <= '0;
        else if (acc && cur.par[beat] != out_par && par_err_cnt != 8'hff) par_err_cnt <= par_err_cnt + 8'd1;
    end
`endif
endmodule

// File: doc/sub_ser.md
Name: sub_ser

Overview:
- Downstream neighbour of the sub2 stage.
- Accepts one bundle per handshake, matching sub2's outputs: scalar my_t, lib_pkg::our_t tag, packed my_t [0:2] and unpacked my_t [3].
- Buffers bundles in a small FIFO and serialises each into a 7-beat my_t stream with valid/ready/last, carrying the our_t tag as sideband.
- Sits between sub2 and the narrow my_t consumer path.

Parameters:
- DEPTH, 2, input bundle FIFO depth in entries; must be a power of two, ≥2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  bundle valid.
- in_ready  out  1  FIFO not full.
- in_i  in  my_t  scalar element.
- in_j  in  lib_pkg::our_t  bundle tag.
- in_k  in  my_t [0:2]  packed element array.
- in_l  in  my_t [3]  unpacked element array.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  my_t  current beat element.
- out_tag  out  lib_pkg::our_t  tag of the bundle being sent; constant for the whole burst.
- out_last  out  1  high on beat 6 only.

Behaviour:
- Reset, synchronous active-high (one clk edge with rst=1):
  - FIFO emptied, pointers cleared, beat counter = 0, FSM = IDLE.
  - Outputs: out_valid=0, out_last=0, out_data='0, out_tag='0, in_ready=1.
- Input handshake:
  - Transfer when in_valid && in_ready; the bundle is written to the FIFO at that edge.
  - in_ready = !full, registered-count based.
  - A simultaneous push and pop while full is NOT allowed; in_ready=0 when full regardless of pop.
- FIFO:
  - DEPTH entries, pointers sized $clog2(DEPTH)+1; wrap-around by pointer MSB.
  - Entry = {i, j, k, l}.
  - Pop occurs on the accepted last beat.
- FSM:
  - IDLE: if FIFO non-empty, latch the head entry into the beat register; go to SEND at the next edge with beat=0.
  - SEND:
    - out_valid=1; out_data selected by beat: 0→i, 1→k[0], 2→k[1], 3→k[2], 4→l[0], 5→l[1], 6→l[2].
    - beat advances only when out_valid && out_ready.
    - On the accepted beat 6: pop the FIFO. If the FIFO still has an entry after the pop, load it and stay in SEND with beat=0 (back-to-back, no bubble); otherwise go to IDLE.
- Latency: bundle accepted into an empty block → first beat out_valid 2 cycles later (write, then load); 7 beats minimum per bundle.
- Stability: while out_valid && !out_ready, out_data, out_tag and out_last hold stable. out_valid never drops without acceptance.
- Mid-burst rst: burst abandoned, FIFO contents discarded, no out_last emitted.
- Element order is index order as declared: k index 0 first, l index 0 first.

Optional Feature:
- Macro: SUB_SER_PARITY_EN.
- Defined:
  - Extra port out_par (out, 1) = ^out_data, combinational from the beat register; reset value 0.
  - Extra port par_err_cnt (out, 8): increments, saturating at 255, on each accepted beat where the input-side parity captured at push differs from the recomputed parity. Parity is stored per element in the FIFO (7 bits/entry).
- Undefined: neither port exists; the FIFO carries no parity bits.

Decomposition:
- my_pkg holds:
  - my_t;
  - SER_BEATS = 7;
  - beat_t = logic [2:0];
  - bundle_t struct {my_t i; lib_pkg::our_t j; my_t [0:2] k; my_t [0:2] l;}. l is repacked from unpacked at the port.
- lib_pkg::our_t is unchanged.
- One natural sub-module: sub_ser_fifo, a generic DEPTH-entry synchronous FIFO of bundle_t with push/pop/full/empty.

Test Plan:
- Single bundle i=1, k={2,3,4}, l={5,6,7}, j=0xA, out_ready=1 → out_data 1,2,3,4,5,6,7 on consecutive cycles; out_tag=0xA throughout; out_last only on 7; first beat 2 cycles after accept.
- Three bundles pushed back-to-back, DEPTH=2, out_ready=0 → in_ready drops after 2 pushes. Then release out_ready → 21 beats with no bubbles and 3 out_last pulses.
- out_ready toggled 1/0 every cycle → every beat held stable while stalled; order unchanged; 14 cycles per bundle.
- rst asserted at beat 3 of a burst with one bundle queued → next cycle out_valid=0, in_ready=1, FIFO empty; no further beats.
- SUB_SER_PARITY_EN defined, corrupt the stored element k[1] via force → par_err_cnt=1 after beat 2; out_par matches ^out_data on all beats.
- Pointer wrap: 10 bundles streamed with DEPTH=2 → all 70 beats in order, tags match push order.
